// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// pending scoreboard used by the hazard unit for load-use stalls.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                mark_en,
    input  logic [AW-1:0]       mark_addr,
    input  logic                flush
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             wr0_ok;
    logic             wr1_ok;
    logic [AW-1:0]    ra;
    logic             hit0;
    logic             hit1;
    logic             zero_rd;

    assign wr0_ok = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
    assign wr1_ok = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);

    // Port 1 is written last so it wins a same-address conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    // Writeback clears before issue sets, so a same-cycle mark keeps the register pending.
    always_comb begin
        pending_next = pending;
        if (flush) begin
            pending_next = '0;
        end else begin
            if (wr0_en)  pending_next[wr0_addr]  = 1'b0;
            if (wr1_en)  pending_next[wr1_addr]  = 1'b0;
            if (mark_en) pending_next[mark_addr] = 1'b1;
        end
        if (ZERO_REG != 0) pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        zero_rd = 1'b0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra      = rd_addr[i*AW +: AW];
            hit0    = wr0_en && (wr0_addr == ra);
            hit1    = wr1_en && (wr1_addr == ra);
            zero_rd = rst || (ZERO_REG != 0 && ra == '0);
            if (zero_rd)   rd_data[i*XLEN +: XLEN] = '0;
            else if (hit1) rd_data[i*XLEN +: XLEN] = wr1_data;
            else if (hit0) rd_data[i*XLEN +: XLEN] = wr0_data;
            else           rd_data[i*XLEN +: XLEN] = regs[ra];
            rd_busy[i] = !zero_rd && pending[ra] && !(hit0 || hit1);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Default build (XLEN=32, NREGS=32, NRD=2, ZERO_REG=1)
    logic        a_w0e, a_w1e, a_me, a_fl;
    logic [4:0]  a_w0a, a_w1a, a_ma;
    logic [31:0] a_w0d, a_w1d;
    logic [9:0]  a_rda;
    logic [63:0] a_rdd;
    logic [1:0]  a_rdb;

    // ZERO_REG=0 build
    logic        b_w0e, b_w1e, b_me, b_fl;
    logic [4:0]  b_w0a, b_w1a, b_ma;
    logic [31:0] b_w0d, b_w1d;
    logic [9:0]  b_rda;
    logic [63:0] b_rdd;
    logic [1:0]  b_rdb;

    // Wide build (XLEN=64, NREGS=16, NRD=4)
    logic         c_w0e, c_w1e, c_me, c_fl;
    logic [3:0]   c_w0a, c_w1a, c_ma;
    logic [63:0]  c_w0d, c_w1d;
    logic [15:0]  c_rda;
    logic [255:0] c_rdd;
    logic [3:0]   c_rdb;

    regfile_mp dut_a (
        .clk(clk), .rst(rst),
        .wr0_en(a_w0e), .wr0_addr(a_w0a), .wr0_data(a_w0d),
        .wr1_en(a_w1e), .wr1_addr(a_w1a), .wr1_data(a_w1d),
        .rd_addr(a_rda), .rd_data(a_rdd), .rd_busy(a_rdb),
        .mark_en(a_me), .mark_addr(a_ma), .flush(a_fl)
    );

    regfile_mp #(.ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst),
        .wr0_en(b_w0e), .wr0_addr(b_w0a), .wr0_data(b_w0d),
        .wr1_en(b_w1e), .wr1_addr(b_w1a), .wr1_data(b_w1d),
        .rd_addr(b_rda), .rd_data(b_rdd), .rd_busy(b_rdb),
        .mark_en(b_me), .mark_addr(b_ma), .flush(b_fl)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) dut_c (
        .clk(clk), .rst(rst),
        .wr0_en(c_w0e), .wr0_addr(c_w0a), .wr0_data(c_w0d),
        .wr1_en(c_w1e), .wr1_addr(c_w1a), .wr1_data(c_w1d),
        .rd_addr(c_rda), .rd_data(c_rdd), .rd_busy(c_rdb),
        .mark_en(c_me), .mark_addr(c_ma), .flush(c_fl)
    );

    // Reference model for the default build
    logic [31:0] m_reg [32];
    bit          m_pend [32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (rst || a == 5'd0)         return 32'd0;
        if (a_w1e && a_w1a == a)      return a_w1d;
        if (a_w0e && a_w0a == a)      return a_w0d;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (rst || a == 5'd0)                           return 1'b0;
        if ((a_w1e && a_w1a == a) || (a_w0e && a_w0a == a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (a_fl) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            end else begin
                if (a_w0e) m_pend[a_w0a] = 1'b0;
                if (a_w1e) m_pend[a_w1a] = 1'b0;
                if (a_me)  m_pend[a_ma]  = 1'b1;
            end
            m_pend[0] = 1'b0;
            if (a_w0e && a_w0a != 5'd0) m_reg[a_w0a] = a_w0d;
            if (a_w1e && a_w1a != 5'd0) m_reg[a_w1a] = a_w1d;
        end
    endtask

    task automatic check_a(input string tag);
        logic [4:0] ra;
        for (int p = 0; p < 2; p++) begin
            ra = a_rda[p*5 +: 5];
            check($sformatf("%s_data%0d", tag, p), {32'd0, a_rdd[p*32 +: 32]}, {32'd0, exp_data(ra)});
            check($sformatf("%s_busy%0d", tag, p), {63'd0, a_rdb[p]}, {63'd0, exp_busy(ra)});
        end
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle(input string tag);
        #1;
        check_a(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_a();
        a_w0e = 1'b0; a_w1e = 1'b0; a_me = 1'b0; a_fl = 1'b0;
    endtask

    task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
        a_rda = {p1, p0};
    endtask

    logic [63:0] cv [4];

    initial begin
        rst = 1'b1;
        idle_a();
        a_w0a = '0; a_w1a = '0; a_ma = '0; a_w0d = '0; a_w1d = '0; a_rda = '0;
        b_w0e = 0; b_w1e = 0; b_me = 0; b_fl = 0; b_w0a = '0; b_w1a = '0; b_ma = '0;
        b_w0d = '0; b_w1d = '0; b_rda = '0;
        c_w0e = 0; c_w1e = 0; c_me = 0; c_fl = 0; c_w0a = '0; c_w1a = '0; c_ma = '0;
        c_w0d = '0; c_w1d = '0; c_rda = '0;
        model_reset();
        @(negedge clk);
        cycle("reset");
        rst = 1'b0;

        // Preload reg5 and mark it pending, then assert reset between edges
        a_w0e = 1; a_w0a = 5'd5; a_w0d = 32'hDEAD_BEEF; a_me = 1; a_ma = 5'd5;
        rd_a(5'd5, 5'd0);
        cycle("preload");
        idle_a();
        cycle("preload_stored");
        check("preload_busy_set", {63'd0, a_rdb[0]}, 64'd1);
        rst = 1'b1;
        model_reset();
        a_w0e = 1; a_w0a = 5'd5; a_w0d = 32'h1234_0000; a_me = 1; a_ma = 5'd5;
        #1;
        check("rst_async_data", {32'd0, a_rdd[31:0]}, 64'd0);
        check("rst_async_busy", {63'd0, a_rdb[0]}, 64'd0);
        cycle("rst_held");
        rst = 1'b0;
        idle_a();
        cycle("post_rst");
        check("post_rst_reg5", {32'd0, a_rdd[31:0]}, 64'd0);

        // Write with same-cycle bypass
        a_w0e = 1; a_w0a = 5'd3; a_w0d = 32'h1234_5678; rd_a(5'd3, 5'd3);
        cycle("bypass");
        idle_a();
        cycle("bypass_stored");
        check("bypass_stored_val", {32'd0, a_rdd[31:0]}, 64'h1234_5678);

        // Zero register
        a_w1e = 1; a_w1a = 5'd0; a_w1d = 32'hFFFF_FFFF; a_me = 1; a_ma = 5'd0; rd_a(5'd0, 5'd0);
        cycle("zero_wr");
        idle_a();
        cycle("zero_after");

        // Port conflict: port 1 wins
        a_w0e = 1; a_w0a = 5'd7; a_w0d = 32'h1; a_w1e = 1; a_w1a = 5'd7; a_w1d = 32'h2;
        rd_a(5'd7, 5'd3);
        cycle("conflict");
        idle_a();
        cycle("conflict_stored");
        check("conflict_val", {32'd0, a_rdd[31:0]}, 64'h2);

        // Scoreboard
        a_me = 1; a_ma = 5'd9; rd_a(5'd9, 5'd7);
        cycle("mark9");
        idle_a();
        cycle("busy9");
        check("busy9_set", {63'd0, a_rdb[0]}, 64'd1);
        a_w1e = 1; a_w1a = 5'd9; a_w1d = 32'hA5A5_A5A5;
        cycle("wb9");
        idle_a();
        cycle("wb9_after");
        a_me = 1; a_ma = 5'd9; a_w0e = 1; a_w0a = 5'd9; a_w0d = 32'h0000_0011;
        cycle("remark9");
        idle_a();
        cycle("remark9_after");
        check("remark9_busy", {63'd0, a_rdb[0]}, 64'd1);

        // Flush wins over a same-cycle mark
        a_me = 1; a_ma = 5'd1; rd_a(5'd1, 5'd2); cycle("mark1");
        a_ma = 5'd2; cycle("mark2");
        a_ma = 5'd3; cycle("mark3");
        a_fl = 1; a_ma = 5'd4; cycle("flush");
        idle_a();
        rd_a(5'd1, 5'd2); cycle("flush_12");
        check("flush_busy_12", {62'd0, a_rdb}, 64'd0);
        rd_a(5'd3, 5'd4); cycle("flush_34");
        check("flush_busy_34", {62'd0, a_rdb}, 64'd0);

        // ZERO_REG=0 build: register 0 is ordinary storage
        b_w1e = 1; b_w1a = 5'd0; b_w1d = 32'hFFFF_FFFF; b_me = 1; b_ma = 5'd0; b_rda = '0;
        #1;
        check("nz_bypass", {32'd0, b_rdd[31:0]}, 64'hFFFF_FFFF);
        @(negedge clk);
        b_w1e = 0; b_me = 0;
        #1;
        check("nz_stored", {32'd0, b_rdd[31:0]}, 64'hFFFF_FFFF);
        check("nz_busy", {63'd0, b_rdb[0]}, 64'd1);
        @(negedge clk);

        // Wide build: four independent 64-bit reads
        for (int i = 0; i < 4; i++) cv[i] = {$urandom, $urandom};
        c_w0e = 1; c_w0a = 4'd15; c_w0d = cv[0]; c_w1e = 1; c_w1a = 4'd1; c_w1d = cv[1];
        @(negedge clk);
        c_w0a = 4'd8; c_w0d = cv[2]; c_w1a = 4'd0; c_w1d = cv[3];
        @(negedge clk);
        c_w0e = 0; c_w1e = 0;
        c_rda = {4'd0, 4'd8, 4'd1, 4'd15};
        #1;
        check("wide_r15", c_rdd[63:0],    cv[0]);
        check("wide_r1",  c_rdd[127:64],  cv[1]);
        check("wide_r8",  c_rdd[191:128], cv[2]);
        check("wide_r0",  c_rdd[255:192], 64'd0);
        check("wide_busy", {60'd0, c_rdb}, 64'd0);
        @(negedge clk);

        // Randomized traffic on the default build
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            a_w0e = 1'($urandom_range(0, 1));
            a_w1e = 1'($urandom_range(0, 1));
            a_me  = 1'($urandom_range(0, 1));
            a_fl  = ($urandom_range(0, 19) == 0);
            a_w0a = 5'($urandom_range(0, 15));
            a_w1a = 5'($urandom_range(0, 15));
            a_ma  = 5'($urandom_range(0, 15));
            a_w0d = $urandom;
            a_w1d = $urandom;
            rd_a(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            if (rst) model_reset();
            cycle("rand");
        end

        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
